// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO write arbiter:
// state encoding, a constant clog2 and the packed-lane offset helper.
package fifo_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // LSB position of lane idx inside a packed bus of w-bit lanes.
    function automatic int lane_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first asserted req bit after 'last',
// wrapping, with 'last' itself considered at the very end.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   last,
    output logic                  valid,
    output logic [clog2(N)-1:0]   idx
);

    localparam int W = clog2(N);

    int           j;
    logic [W-1:0] jj;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        for (int i = 1; i <= N; i++) begin
            j  = (int'(last) + i) % N;
            jj = W'(j);
            if (!valid && req[jj]) begin
                valid = 1'b1;
                idx   = jj;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers,
// with full-flag throttling and a per-grant burst cap for fairness.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int FIFO_w    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*FIFO_w-1:0]   data_i,
    output logic [N_REQ-1:0]          ack_o,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [clog2(N_REQ)-1:0]   owner_o,
    input  logic                      fifo_full_i,
    output logic                      fifo_wr_en_o,
    output logic [FIFO_w-1:0]         fifo_data_o,
    output logic                      stall_o
);

    localparam int OW = clog2(N_REQ);
    localparam int CW = clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

    logic [1:0]    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_owner_q, last_owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          active;
    logic          owner_req;
    logic          wr;
    logic          release_grant;
    logic [OW-1:0] pick_last;
    logic          pick_valid;
    logic [OW-1:0] pick_idx;

    assign active        = (state_q != ST_IDLE);
    assign owner_req     = req_i[owner_q];
    assign wr            = active & owner_req & ~fifo_full_i;
    assign release_grant = ~owner_req | (wr & (cnt_q == CNT_LAST));

    // On release the search starts after the outgoing owner, so a burst-limited
    // owner is only re-granted when nobody else is asking.
    assign pick_last = active ? owner_q : last_owner_q;

    rr_picker #(
        .N (N_REQ)
    ) u_picker (
        .req   (req_i),
        .last  (pick_last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign fifo_wr_en_o = wr;
    assign stall_o      = active & owner_req & fifo_full_i;
    assign owner_o      = owner_q;
    assign fifo_data_o  = active ? data_i[lane_lsb(int'(owner_q), FIFO_w) +: FIFO_w]
                                 : '0;

    always_comb begin
        gnt_o = '0;
        ack_o = '0;
        if (active) begin
            gnt_o[owner_q] = 1'b1;
            ack_o[owner_q] = wr;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_GRANT, ST_STALL: begin
                if (release_grant) begin
                    last_owner_d = owner_q;
                    cnt_d        = '0;
                    if (pick_valid) begin
                        state_d = ST_GRANT;
                        owner_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        owner_d = '0;
                    end
                end else if (wr) begin
                    state_d = ST_GRANT;
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    state_d = ST_STALL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(N_REQ - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule
